binary_to_bcd_serial: RTL and testbench

BINARY_TO_BCD_SERIAL -- requirements
Module: binary_to_bcd_serial

---
 rtl/bcd_pkg.sv | 35 +++
 rtl/binary_to_bcd_serial_if.sv | 25 ++
 rtl/bcd_digit_adjust.sv | 12 +
 rtl/binary_to_bcd_serial.sv | 112 +++++++++++
 tb/tb_binary_to_bcd_serial.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the serial binary-to-BCD converter: FSM encoding
// and the elaboration-time sizing helpers.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // True when DIGITS decimal digits can represent the largest WIDTH-bit value.
  function automatic bit digits_fit(input int width, input int digits);
    longint limit;
    longint maxval;
    limit = 1;
    for (int i = 0; i < digits; i++) begin
      limit = limit * 10;
    end
    maxval = (longint'(1) << width) - 1;
    return limit > maxval;
  endfunction

endpackage

// File: rtl/binary_to_bcd_serial_if.sv
// Handshake bundle between a producer of binary values and the converter.
interface binary_to_bcd_serial_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);

  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      binary;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd;
  logic                  busy;

  modport master (
    output in_valid, binary, out_ready,
    input  in_ready, out_valid, bcd, busy
  );

  modport slave (
    input  in_valid, binary, out_ready,
    output in_ready, out_valid, bcd, busy
  );

endinterface

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adjust (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = (din >= 4'd5) ? din + 4'd3 : din;
  end

endmodule

// File: rtl/binary_to_bcd_serial.sv
// Serial shift-and-add-3 converter: one binary bit per clock, MSB first,
// with a valid/ready handshake on both the operand and the result side.
module binary_to_bcd_serial
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  binary_to_bcd_serial_if.slave  bus
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = clog2(WIDTH + 1);

  if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $error("binary_to_bcd_serial: WIDTH must be within 4..32");
  end

  if (!digits_fit(WIDTH, DIGITS)) begin : g_bad_digits
    $error("binary_to_bcd_serial: DIGITS too small for WIDTH");
  end

  state_t               state;
  state_t               state_next;
  logic [WIDTH-1:0]     sreg;
  logic [BW-1:0]        acc;
  logic [BW-1:0]        adj;
  logic [CW-1:0]        cnt;
  logic [BW+WIDTH-1:0]  shifted;
  logic                 accept;
  logic                 in_ready;
  logic                 out_valid;
  logic                 busy;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_adjust u_adjust (
      .din  (acc[4*g +: 4]),
      .dout (adj[4*g +: 4])
    );
  end

  always_comb begin
    shifted = {adj, sreg} << 1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Status outputs decode from the state register only; accept is internal.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == CW'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The accumulator is only touched on acceptance and while shifting,
  // so the result stays put in DONE and afterwards in IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg <= '0;
      acc  <= '0;
      cnt  <= '0;
    end else if (accept) begin
      sreg <= bus.binary;
      acc  <= '0;
      cnt  <= CW'(WIDTH);
    end else if (state == SHIFT) begin
      acc  <= shifted[BW+WIDTH-1:WIDTH];
      sreg <= shifted[WIDTH-1:0];
      cnt  <= cnt - CW'(1);
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.bcd       = acc;

endmodule

// File: tb/tb_binary_to_bcd_serial.sv
// Directed bench for binary_to_bcd_serial at WIDTH 8, 4 and 16.
module tb_binary_to_bcd_serial;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  binary_to_bcd_serial_if #(.WIDTH(8),  .DIGITS(3)) bus8 ();
  binary_to_bcd_serial_if #(.WIDTH(4),  .DIGITS(2)) bus4 ();
  binary_to_bcd_serial_if #(.WIDTH(16), .DIGITS(5)) bus16 ();

  binary_to_bcd_serial #(.WIDTH(8),  .DIGITS(3)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  binary_to_bcd_serial #(.WIDTH(4),  .DIGITS(2)) dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
  binary_to_bcd_serial #(.WIDTH(16), .DIGITS(5)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] to_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic convert8(input logic [7:0] v, output logic [11:0] res, output int lat,
                          output logic busy1, output logic valid);
    bus8.binary    = v;
    bus8.in_valid  = 1'b1;
    bus8.out_ready = 1'b0;
    tick;
    bus8.in_valid = 1'b0;
    bus8.binary   = ~v;
    busy1 = bus8.busy;
    lat   = 0;
    while (bus8.out_valid !== 1'b1 && lat < 40) begin
      tick;
      lat++;
    end
    valid = bus8.out_valid;
    res   = bus8.bcd;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    tick;
    if ({bus8.in_ready, bus8.out_valid, bus8.busy} !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL reset_status: got {in_ready,out_valid,busy}=%b expected 100",
               {bus8.in_ready, bus8.out_valid, bus8.busy});
    end
    vectors++;
    if (bus8.bcd !== 12'h000) begin
      miscompares++;
      $display("[TB] FAIL reset_bcd8: got %h expected 000", bus8.bcd);
    end
    vectors++;
    if ({bus4.bcd, bus16.bcd} !== 28'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_bcd4_16: got %h/%h expected 00/00000", bus4.bcd, bus16.bcd);
    end
    vectors++;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_conversions;
    logic [7:0]  vin  [8] = '{8'd255, 8'd0, 8'd99, 8'd100, 8'd1, 8'd9, 8'd10, 8'd128};
    logic [11:0] vexp [8] = '{12'h255, 12'h000, 12'h099, 12'h100, 12'h001, 12'h009, 12'h010, 12'h128};
    logic [11:0] res;
    int          lat;
    logic        busy1;
    logic        valid;
    for (int i = 0; i < 8; i++) begin
      convert8(vin[i], res, lat, busy1, valid);
      if (busy1 !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL busy_in_shift v=%0d: got %b expected 1", vin[i], busy1);
      end
      vectors++;
      if (lat !== 8 || valid !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL latency8 v=%0d: got %0d (valid=%b) expected 8", vin[i], lat, valid);
      end
      vectors++;
      if (res !== vexp[i]) begin
        miscompares++;
        $display("[TB] FAIL result8 v=%0d: got %h expected %h", vin[i], res, vexp[i]);
      end
      vectors++;
      if (bus8.in_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL ready_in_done v=%0d: got %b expected 0", vin[i], bus8.in_ready);
      end
      vectors++;
      bus8.out_ready = 1'b1;
      tick;
      bus8.out_ready = 1'b0;
      if ({bus8.out_valid, bus8.in_ready, bus8.bcd} !== {2'b01, vexp[i]}) begin
        miscompares++;
        $display("[TB] FAIL idle_hold v=%0d: got valid=%b ready=%b bcd=%h expected 0 1 %h",
                 vin[i], bus8.out_valid, bus8.in_ready, bus8.bcd, vexp[i]);
      end
      vectors++;
    end
  endtask

  task automatic test_backpressure;
    logic [11:0] res;
    int          lat;
    logic        busy1;
    logic        valid;
    convert8(8'd123, res, lat, busy1, valid);
    if (res !== 12'h123 || valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL bp_result: got %h (valid=%b) expected 123", res, valid);
    end
    vectors++;
    for (int c = 0; c < 5; c++) begin
      bus8.in_valid = 1'b1;
      bus8.binary   = 8'd5;
      tick;
      if ({bus8.out_valid, bus8.in_ready, bus8.bcd} !== {2'b10, 12'h123}) begin
        miscompares++;
        $display("[TB] FAIL bp_hold cycle=%0d: got valid=%b ready=%b bcd=%h expected 1 0 123",
                 c, bus8.out_valid, bus8.in_ready, bus8.bcd);
      end
      vectors++;
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    tick;
    bus8.out_ready = 1'b0;
    if ({bus8.out_valid, bus8.in_ready} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL bp_release: got valid=%b ready=%b expected 0 1",
               bus8.out_valid, bus8.in_ready);
    end
    vectors++;
    tick;
    if ({bus8.busy, bus8.in_ready, bus8.bcd} !== {2'b01, 12'h123}) begin
      miscompares++;
      $display("[TB] FAIL bp_idle_stays: got busy=%b ready=%b bcd=%h expected 0 1 123",
               bus8.busy, bus8.in_ready, bus8.bcd);
    end
    vectors++;
  endtask

  task automatic test_reset_abort;
    logic [11:0] res;
    int          lat;
    logic        busy1;
    logic        valid;
    logic        seen_valid;
    bus8.binary   = 8'd200;
    bus8.in_valid = 1'b1;
    tick;
    bus8.in_valid = 1'b0;
    tick;
    tick;
    tick;
    if (bus8.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL abort_busy: got %b expected 1", bus8.busy);
    end
    vectors++;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    if ({bus8.in_ready, bus8.busy, bus8.out_valid, bus8.bcd} !== {3'b100, 12'h000}) begin
      miscompares++;
      $display("[TB] FAIL abort_state: got ready=%b busy=%b valid=%b bcd=%h expected 1 0 0 000",
               bus8.in_ready, bus8.busy, bus8.out_valid, bus8.bcd);
    end
    vectors++;
    seen_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick;
      if (bus8.out_valid === 1'b1) seen_valid = 1'b1;
    end
    if (seen_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_no_result: got out_valid seen=%b expected 0", seen_valid);
    end
    vectors++;
    bus8.binary   = 8'd77;
    bus8.in_valid = 1'b1;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    bus8.in_valid = 1'b0;
    if ({bus8.in_ready, bus8.busy} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL reset_priority: got ready=%b busy=%b expected 1 0",
               bus8.in_ready, bus8.busy);
    end
    vectors++;
    convert8(8'd37, res, lat, busy1, valid);
    if (res !== 12'h037 || lat !== 8) begin
      miscompares++;
      $display("[TB] FAIL after_abort: got %h lat=%0d expected 037 lat=8", res, lat);
    end
    vectors++;
    bus8.out_ready = 1'b1;
    tick;
    bus8.out_ready = 1'b0;
  endtask

  task automatic test_width4;
    logic [19:0] e;
    int          lat;
    for (int v = 0; v < 16; v++) begin
      e = to_bcd(v);
      bus4.binary    = 4'(v);
      bus4.in_valid  = 1'b1;
      bus4.out_ready = 1'b0;
      tick;
      bus4.in_valid = 1'b0;
      lat = 0;
      while (bus4.out_valid !== 1'b1 && lat < 40) begin
        tick;
        lat++;
      end
      if (lat !== 4) begin
        miscompares++;
        $display("[TB] FAIL latency4 v=%0d: got %0d expected 4", v, lat);
      end
      vectors++;
      if (bus4.bcd !== e[7:0]) begin
        miscompares++;
        $display("[TB] FAIL result4 v=%0d: got %h expected %h", v, bus4.bcd, e[7:0]);
      end
      vectors++;
      bus4.out_ready = 1'b1;
      tick;
      bus4.out_ready = 1'b0;
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] cur;
    logic [15:0] nxt;
    logic [19:0] e;
    int          lat;
    cur = 16'hFFFF;
    bus16.out_ready = 1'b1;
    bus16.in_valid  = 1'b1;
    bus16.binary    = cur;
    for (int i = 0; i < 1000; i++) begin
      if (bus16.in_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL b2b_ready i=%0d: got %b expected 1", i, bus16.in_ready);
      end
      vectors++;
      tick;
      nxt = (i == 0) ? 16'd0 : 16'($urandom_range(0, 65535));
      bus16.binary = nxt;
      lat = 0;
      while (bus16.out_valid !== 1'b1 && lat < 40) begin
        tick;
        lat++;
      end
      e = (i == 0) ? 20'h65535 : to_bcd(cur);
      if (lat !== 16) begin
        miscompares++;
        $display("[TB] FAIL latency16 v=%0d: got %0d expected 16", cur, lat);
      end
      vectors++;
      if (bus16.bcd !== e) begin
        miscompares++;
        $display("[TB] FAIL result16 v=%0d: got %h expected %h", cur, bus16.bcd, e);
      end
      vectors++;
      tick;
      cur = nxt;
    end
    bus16.in_valid  = 1'b0;
    bus16.out_ready = 1'b0;
    tick;
  endtask

  initial begin
    rst_n = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b0;
    bus8.binary    = '0;
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b0;
    bus4.binary    = '0;
    bus16.in_valid  = 1'b0;
    bus16.out_ready = 1'b0;
    bus16.binary    = '0;
    test_reset;
    test_conversions;
    test_backpressure;
    test_reset_abort;
    test_width4;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
